// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory-stage controller.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/dffr_n.sv
// Single-bit D flop with asynchronous active-low clear; every register in
// mem_ctrl is built from arrays of this cell.
module dffr_n (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-stage controller: turns an EX/MEM load/store into a req/ready/done
// transaction on a multi-cycle data memory and stalls the pipeline meanwhile.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_done,
  input  logic [DATA_W-1:0] dm_rdata
);

  logic [1:0]        state_d, state_q;
  state_e            state;
  logic [ADDR_W-1:0] req_addr_d, req_addr_q;
  logic [DATA_W-1:0] req_wdata_d, req_wdata_q;
  logic              req_wr_d, req_wr_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              err_d, err_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  logic access, unaligned, start;

  dffr_n u_state_ff [1:0]        (.clk(clk), .rst_n(rst), .d(state_d),     .q(state_q));
  dffr_n u_addr_ff  [ADDR_W-1:0] (.clk(clk), .rst_n(rst), .d(req_addr_d),  .q(req_addr_q));
  dffr_n u_wdata_ff [DATA_W-1:0] (.clk(clk), .rst_n(rst), .d(req_wdata_d), .q(req_wdata_q));
  dffr_n u_wr_ff                 (.clk(clk), .rst_n(rst), .d(req_wr_d),    .q(req_wr_q));
  dffr_n u_rdata_ff [DATA_W-1:0] (.clk(clk), .rst_n(rst), .d(rdata_d),     .q(rdata_q));
  dffr_n u_err_ff                (.clk(clk), .rst_n(rst), .d(err_d),       .q(err_q));
  dffr_n u_cnt_ff   [CNT_W-1:0]  (.clk(clk), .rst_n(rst), .d(cnt_d),       .q(cnt_q));

  assign state = state_e'(state_q);

  assign access    = valid_in & (mem_rd_in | mem_wr_in);
  assign unaligned = access & addr_in[0];
  // Gated by reset so the request and stall drop the instant reset asserts,
  // even while a valid instruction is still sitting on the inputs.
  assign start     = rst & access & ~addr_in[0] & (state == ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wr_d    = req_wr_q;
    rdata_d     = rdata_q;
    dm_req      = 1'b0;
    dm_addr     = req_addr_q;
    dm_wdata    = req_wdata_q;
    dm_wr       = req_wr_q;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          dm_req      = 1'b1;
          dm_addr     = addr_in;
          dm_wdata    = wdata_in;
          dm_wr       = mem_wr_in;
          req_addr_d  = addr_in;
          req_wdata_d = wdata_in;
          req_wr_d    = mem_wr_in;
          state_d     = dm_ready ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        dm_req = 1'b1;
        if (dm_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dm_done) begin
          state_d = ST_DONE;
          if (!req_wr_q) rdata_d = dm_rdata;
        end
      end
      // The instruction is still on the inputs here; returning to IDLE
      // without a request keeps it from being issued twice.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_stall = start | (state == ST_REQ) | (state == ST_WAIT);
  assign err_d     = err_q | unaligned;
  assign cnt_d     = (mem_stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  assign rdata_out = rdata_q;
  assign err_out   = err_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: the bench plays the memory, queues the load
// data it will return, and checks rdata_out against the queue in DONE.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_rd_in, mem_wr_in;
  logic [15:0] addr_in, wdata_in;
  logic        mem_stall, err_out;
  logic [15:0] rdata_out, stall_cnt;
  logic        dm_req, dm_wr;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_ready, dm_done;
  logic [15:0] dm_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_rd;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .mem_stall(mem_stall), .rdata_out(rdata_out), .err_out(err_out),
    .stall_cnt(stall_cnt),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_done(dm_done), .dm_rdata(dm_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd);
    valid_in = v; mem_rd_in = rd; mem_wr_in = wr; addr_in = a; wdata_in = wd;
  endtask

  task automatic mem(input logic rdy, input logic dn, input logic [15:0] rd);
    dm_ready = rdy; dm_done = dn; dm_rdata = rd;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0);
    mem(0, 0, 16'h0);

    // Reset state
    @(negedge clk); #1;
    check("rst_req",   dm_req,    0);
    check("rst_stall", mem_stall, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_err",   err_out,   0);
    check("rst_cnt",   stall_cnt, 0);
    rst = 1'b1;

    // Aligned load to 0x0010: ready in start cycle, done next cycle
    @(negedge clk);
    drive(1, 1, 0, 16'h0010, 16'h0); mem(1, 0, 16'h0);
    exp_q.push_back(16'hBEEF);
    #1;
    check("ld_c1_req",   dm_req,    1);
    check("ld_c1_stall", mem_stall, 1);
    check("ld_c1_addr",  dm_addr,   16'h0010);
    check("ld_c1_wr",    dm_wr,     0);
    @(negedge clk); mem(0, 1, 16'hBEEF); #1;
    check("ld_c2_stall", mem_stall, 1);
    check("ld_c2_req",   dm_req,    0);
    @(negedge clk); mem(0, 0, 16'h0); #1;
    check("ld_c3_stall", mem_stall, 0);
    check("ld_c3_req",   dm_req,    0);
    exp_rd = exp_q.pop_front();
    check("ld_c3_rdata", rdata_out, exp_rd);
    check("ld_c3_cnt",   stall_cnt, 2);
    @(negedge clk); drive(0, 0, 0, 16'h0, 16'h0); #1;
    check("ld_hold_rdata", rdata_out, 16'hBEEF);

    // Store 0x1234 to 0x0020 with ready held low three cycles; inputs are
    // perturbed after the start cycle to show the latched request is used
    @(negedge clk);
    drive(1, 0, 1, 16'h0020, 16'h1234); mem(0, 0, 16'h0); #1;
    check("st_c1_req",   dm_req,   1);
    check("st_c1_addr",  dm_addr,  16'h0020);
    check("st_c1_wdata", dm_wdata, 16'h1234);
    check("st_c1_wr",    dm_wr,    1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      drive(1, 0, 1, 16'h0040, 16'hAAAA);
      if (i == 4) mem(1, 0, 16'h0);
      #1;
      check($sformatf("st_c%0d_req", i),   dm_req,    1);
      check($sformatf("st_c%0d_addr", i),  dm_addr,   16'h0020);
      check($sformatf("st_c%0d_wdata", i), dm_wdata,  16'h1234);
      check($sformatf("st_c%0d_wr", i),    dm_wr,     1);
      check($sformatf("st_c%0d_stall", i), mem_stall, 1);
    end
    @(negedge clk); drive(1, 0, 1, 16'h0020, 16'h1234); mem(0, 1, 16'h5555); #1;
    check("st_wait_req",   dm_req,    0);
    check("st_wait_stall", mem_stall, 1);
    @(negedge clk); mem(0, 0, 16'h0); #1;
    check("st_done_stall", mem_stall, 0);
    check("st_rdata_kept", rdata_out, 16'hBEEF);
    check("st_cnt",        stall_cnt, 7);
    @(negedge clk); drive(0, 0, 0, 16'h0, 16'h0);

    // Unaligned load to 0x0011
    @(negedge clk); drive(1, 1, 0, 16'h0011, 16'h0); #1;
    check("ua_req",   dm_req,    0);
    check("ua_stall", mem_stall, 0);
    check("ua_err0",  err_out,   0);
    @(negedge clk); drive(0, 0, 0, 16'h0, 16'h0); #1;
    check("ua_err1", err_out, 1);
    @(negedge clk); #1;
    check("ua_err_held", err_out,   1);
    check("ua_cnt",      stall_cnt, 7);

    // NOP carrying mem_rd_in=1
    @(negedge clk); drive(0, 1, 0, 16'h0030, 16'h0); #1;
    check("nop_req",   dm_req,    0);
    check("nop_stall", mem_stall, 0);
    @(negedge clk); drive(0, 0, 0, 16'h0, 16'h0); #1;
    check("nop_cnt", stall_cnt, 7);

    // Reset asserted while in WAIT, then a stray done after release
    @(negedge clk); drive(1, 1, 0, 16'h0060, 16'h0); mem(1, 0, 16'h0); #1;
    check("rw_c1_req", dm_req, 1);
    @(negedge clk); mem(0, 0, 16'h0); #1;
    check("rw_wait_stall", mem_stall, 1);
    #1; rst = 1'b0; #1;
    check("rw_req",   dm_req,    0);
    check("rw_stall", mem_stall, 0);
    check("rw_err",   err_out,   0);
    check("rw_rdata", rdata_out, 0);
    check("rw_cnt",   stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1; drive(0, 0, 0, 16'h0, 16'h0); mem(0, 1, 16'hDEAD); #1;
    check("rw_stray_req",   dm_req,    0);
    check("rw_stray_stall", mem_stall, 0);
    @(negedge clk); mem(0, 0, 16'h0); #1;
    check("rw_stray_rdata", rdata_out, 0);
    check("rw_stray_cnt",   stall_cnt, 0);

    // Back-to-back loads; load A stays on the inputs through its DONE cycle
    @(negedge clk);
    drive(1, 1, 0, 16'h0050, 16'h0); mem(1, 0, 16'h0);
    exp_q.push_back(16'h1111);
    #1;
    check("bb_a_req",  dm_req,  1);
    check("bb_a_addr", dm_addr, 16'h0050);
    @(negedge clk); mem(0, 1, 16'h1111); #1;
    check("bb_a_wait_req", dm_req, 0);
    @(negedge clk); mem(0, 0, 16'h0); #1;
    check("bb_a_done_req",   dm_req,    0);
    check("bb_a_done_stall", mem_stall, 0);
    exp_rd = exp_q.pop_front();
    check("bb_a_rdata", rdata_out, exp_rd);
    @(negedge clk);
    drive(1, 1, 0, 16'h0052, 16'h0); mem(1, 0, 16'h0);
    exp_q.push_back(16'h2222);
    #1;
    check("bb_b_req",  dm_req,  1);
    check("bb_b_addr", dm_addr, 16'h0052);
    @(negedge clk); mem(0, 1, 16'h2222); #1;
    check("bb_b_wait_req", dm_req, 0);
    @(negedge clk); mem(0, 0, 16'h0); drive(0, 0, 0, 16'h0, 16'h0); #1;
    check("bb_b_done_stall", mem_stall, 0);
    exp_rd = exp_q.pop_front();
    check("bb_b_rdata", rdata_out, exp_rd);
    check("bb_cnt",     stall_cnt, 4);
    @(negedge clk); #1;
    check("bb_idle_req", dm_req, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
